// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register fields, multicycle FSM states and
// the forwarding tracker slot layout.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mul_state_t;

   localparam int FWD_NSTAGES = 2;

   typedef struct packed {
      logic     valid;
      regbits_t rd;
      logic     wen;
      logic     load;
   } slot_t;

   // r0 is hardwired zero and never counts as a dependency
   function automatic logic regHit(
      input regbits_t a,
      input regbits_t b
   );
      return (a == b) && (a != '0);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bundle of the forwarding/hazard unit signals with
// unit-side and bench-side views.
interface fwd_hazard_unit_if #(
   parameter int NSRC = 2,
   parameter int SELW = 2
) (
   input logic CLK
);

   logic                 nRST;
   logic                 pipe_en;
   logic                 flush;
   logic                 issue_valid;
   logic [NSRC*5-1:0]    src_reg;
   logic [NSRC-1:0]      src_used;
   logic [4:0]           dst_reg;
   logic                 dst_wen;
   logic                 dst_load;
   logic                 dst_mul;
   logic [NSRC*SELW-1:0] fwd_sel;
   logic                 stall;
   logic                 mul_busy;
   logic                 mul_done;

   modport fu (
      input  CLK, nRST, pipe_en, flush, issue_valid,
      input  src_reg, src_used, dst_reg,
      input  dst_wen, dst_load, dst_mul,
      output fwd_sel, stall, mul_busy, mul_done
   );

   modport tb (
      input  CLK,
      output nRST, pipe_en, flush, issue_valid,
      output src_reg, src_used, dst_reg,
      output dst_wen, dst_load, dst_mul,
      input  fwd_sel, stall, mul_busy, mul_done
   );

endinterface

// File: rtl/fwd_tracker.sv
// Destination tracker: one slot per stage from EX to WB,
// shifting on enable with bubble and flush insertion.
module fwd_tracker
   import cpu_types_pkg::*;
#(
   parameter int NSTAGES = FWD_NSTAGES
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 en,
   input  logic                 bubble,
   input  logic                 flush,
   input  logic                 insValid,
   input  logic [4:0]           insRd,
   input  logic                 insWen,
   input  logic                 insLoad,
   output logic [NSTAGES-1:0]   fwdValid,
   output logic [NSTAGES*5-1:0] fwdRd,
   output logic [NSTAGES-1:0]   fwdWen,
   output logic                 exLoad
);

   slot_t slots [NSTAGES+1];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int j = 0; j <= NSTAGES; j++) begin
            slots[j] <= '0;
         end
      end else if (en) begin
         for (int j = NSTAGES; j > 0; j--) begin
            slots[j] <= slots[j-1];
         end
         // a squashed EX instruction must not reach MEM
         if (flush) begin
            slots[1].valid <= 1'b0;
         end
         if (flush || bubble) begin
            slots[0] <= '0;
         end else begin
            slots[0] <= '{
               valid: insValid,
               rd:    insRd,
               wen:   insWen,
               load:  insLoad
            };
         end
      end
   end

   always_comb begin
      fwdValid = '0;
      fwdRd    = '0;
      fwdWen   = '0;
      for (int j = 0; j < NSTAGES; j++) begin
         fwdValid[j]      = slots[j].valid;
         fwdRd[j*5 +: 5]  = slots[j].rd;
         fwdWen[j]        = slots[j].wen;
      end
      exLoad = slots[0].load;
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use and multicycle
// hazard detection for the in-order pipeline.
module fwd_hazard_unit
   import cpu_types_pkg::*;
#(
   parameter int  NSTAGES = FWD_NSTAGES,
   parameter int  NSRC    = 2,
   parameter int  MUL_LAT = 4,
   localparam int SELW    = $clog2(NSTAGES+1)
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 pipe_en,
   input  logic                 flush,
   input  logic                 issue_valid,
   input  logic [NSRC*5-1:0]    src_reg,
   input  logic [NSRC-1:0]      src_used,
   input  logic [4:0]           dst_reg,
   input  logic                 dst_wen,
   input  logic                 dst_load,
   input  logic                 dst_mul,
   output logic [NSRC*SELW-1:0] fwd_sel,
   output logic                 stall,
   output logic                 mul_busy,
   output logic                 mul_done
);

   localparam int CNTW = $clog2(MUL_LAT);
   localparam logic [CNTW-1:0] CNT_LOAD =
      CNTW'(MUL_LAT-1);

   logic [NSTAGES-1:0]   fwdValid;
   logic [NSTAGES-1:0]   fwdWen;
   logic [NSTAGES*5-1:0] fwdRd;
   logic                 exLoad;

   logic                 loadUse;
   logic                 mulHaz;
   logic                 advance;
   logic                 mulStart;
   logic [NSRC*SELW-1:0] selNxt;

   mul_state_t           state;
   mul_state_t           stateNxt;
   logic [CNTW-1:0]      cnt;
   logic [CNTW-1:0]      cntNxt;
   regbits_t             mulRd;
   regbits_t             mulRdNxt;

   fwd_tracker #(
      .NSTAGES (NSTAGES)
   ) u_tracker (
      .CLK      (CLK),
      .nRST     (nRST),
      .en       (pipe_en),
      .bubble   (stall),
      .flush    (flush),
      .insValid (issue_valid & ~dst_mul),
      .insRd    (dst_reg),
      .insWen   (dst_wen),
      .insLoad  (dst_load),
      .fwdValid (fwdValid),
      .fwdRd    (fwdRd),
      .fwdWen   (fwdWen),
      .exLoad   (exLoad)
   );

   // descending scan so the youngest producer is written last
   always_comb begin
      loadUse = 1'b0;
      mulHaz  = 1'b0;
      selNxt  = '0;
      for (int i = 0; i < NSRC; i++) begin
         for (int j = NSTAGES-1; j >= 0; j--) begin
            if (src_used[i] && fwdValid[j] &&
                fwdWen[j] &&
                regHit(fwdRd[j*5 +: 5],
                       src_reg[i*5 +: 5])) begin
               selNxt[i*SELW +: SELW] = SELW'(j+1);
            end
         end
         if (src_used[i] && fwdValid[0] &&
             fwdWen[0] && exLoad &&
             regHit(fwdRd[4:0],
                    src_reg[i*5 +: 5])) begin
            loadUse = 1'b1;
         end
         if (src_used[i] &&
             regHit(mulRd, src_reg[i*5 +: 5])) begin
            mulHaz = 1'b1;
         end
      end
      if (dst_mul ||
          (dst_wen && regHit(mulRd, dst_reg))) begin
         mulHaz = 1'b1;
      end
   end

   assign stall = issue_valid & ~flush &
                  (loadUse | (mul_busy & mulHaz));
   assign advance  = pipe_en & ~stall & ~flush;
   assign mulStart = advance & issue_valid & dst_mul;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fwd_sel <= '0;
      end else if (pipe_en) begin
         fwd_sel <= advance ? selNxt : '0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         cnt   <= '0;
         mulRd <= '0;
      end else begin
         state <= stateNxt;
         cnt   <= cntNxt;
         mulRd <= mulRdNxt;
      end
   end

   // the unit runs on its own once started, ignoring pipe_en
   always_comb begin
      stateNxt = state;
      cntNxt   = cnt;
      mulRdNxt = mulRd;
      unique case (state)
         IDLE: begin
            if (mulStart) begin
               stateNxt = BUSY;
               cntNxt   = CNT_LOAD;
               mulRdNxt = dst_reg;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               stateNxt = DONE;
            end else begin
               cntNxt = cnt - CNTW'(1);
            end
         end
         DONE: begin
            stateNxt = IDLE;
         end
         default: begin
            stateNxt = IDLE;
         end
      endcase
   end

   assign mul_busy = (state != IDLE);
   assign mul_done = (state == DONE);

endmodule
